// File: rtl/ept_host_block_master_pkg.sv
`default_nettype none
// ============================================================================
// ept_host_block_master_pkg : EPT bus field map, command codes, FSM states
// Rev 1.0
// ============================================================================
package ept_host_block_master_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int LEN_W_DEF  = 8;
    localparam int DATA_W_DEF = 8;

    localparam int UC_IN_W  = 24;
    localparam int UC_OUT_W = 22;

    localparam int BUSY_BIT    = 23;
    localparam int FIFO_EN_BIT = 22;
    localparam int CMD_HI      = 21;
    localparam int CMD_LO      = 19;
    localparam int ADDR_HI     = 18;
    localparam int ADDR_LO     = 16;
    localparam int LEN_HI      = 15;
    localparam int LEN_LO      = 8;
    localparam int DATA_HI     = 7;
    localparam int DATA_LO     = 0;

    typedef enum logic [2:0] {
        CMD_NONE      = 3'd0,
        CMD_BLOCK_OUT = 3'd2,
        CMD_OUT_CONT  = 3'd3,
        CMD_BLOCK_IN  = 3'd4
    } cmd_e;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_DN_SEL     = 4'd1,
        S_DN_CMD     = 4'd2,
        S_DN_CHECK   = 4'd3,
        S_DN_WAIT    = 4'd4,
        S_DN_STROBE  = 4'd5,
        S_DN_GAP     = 4'd6,
        S_DN_END     = 4'd7,
        S_UP_CHECK   = 4'd8,
        S_UP_STROBE  = 4'd9,
        S_UP_CAPTURE = 4'd10,
        S_UP_GAP     = 4'd11,
        S_UP_DRAIN   = 4'd12
    } state_e;

    function automatic logic is_up_cmd(input logic [2:0] cmd);
        return (cmd == CMD_BLOCK_OUT) || (cmd == CMD_OUT_CONT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ept_up_holdreg.sv
`default_nettype none
// ============================================================================
// ept_up_holdreg : single-entry valid/ready output register with last flag
// Rev 1.0
// ============================================================================
module ept_up_holdreg #(
    parameter int DATA_W = 8
) (
    input  logic              uc_clk,
    input  logic              uc_reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              flush,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    // The producer only loads when empty or being accepted, so data never changes under backpressure.
    always_ff @(posedge uc_clk or negedge uc_reset) begin
        if (!uc_reset) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ept_host_block_master.sv
`default_nettype none
// ============================================================================
// ept_host_block_master : host end of the EPT endpoint bus (BLOCK_IN / BLOCK_OUT)
// Optional watchdog: define EPT_XFER_TIMEOUT_EN.   Rev 1.0
// ============================================================================
module ept_host_block_master
    import ept_host_block_master_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int GAP_CYCLES = 1
) (
    input  logic                uc_clk,
    input  logic                uc_reset,
    output logic [UC_IN_W-1:0]  uc_in,
    input  logic [UC_OUT_W-1:0] uc_out,
    input  logic                dn_start,
    input  logic [ADDR_W-1:0]   dn_addr,
    input  logic [LEN_W-1:0]    dn_length,
    input  logic [DATA_W-1:0]   dn_data,
    input  logic                dn_valid,
    output logic                dn_ready,
    output logic                dn_done,
    output logic [ADDR_W-1:0]   up_addr,
    output logic [LEN_W-1:0]    up_length,
    output logic [DATA_W-1:0]   up_data,
    output logic                up_valid,
    input  logic                up_ready,
    output logic                up_last,
    output logic                err
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    state_e              state;
    logic                phase;
    logic [GAP_W-1:0]    gap_cnt;
    logic [LEN_W-1:0]    dn_len;
    logic [LEN_W-1:0]    dn_cnt;
    logic [LEN_W-1:0]    up_rem;

    logic                busy;
    logic                fifo_en;
    logic [2:0]          cmd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    len_q;
    logic [DATA_W-1:0]   data_q;

    logic [2:0]          out_cmd;
    logic [ADDR_W-1:0]   out_addr;
    logic [LEN_W-1:0]    out_len;
    logic [DATA_W-1:0]   out_data;

    logic                timeout;
    logic                up_go;
    logic                hold_load;
    logic                hold_flush;

    assign out_cmd  = uc_out[CMD_HI:CMD_LO];
    assign out_addr = uc_out[ADDR_HI:ADDR_LO];
    assign out_len  = uc_out[LEN_HI:LEN_LO];
    assign out_data = uc_out[DATA_HI:DATA_LO];

    assign uc_in = {busy, fifo_en, cmd_q, addr_q, len_q, data_q};

    // A new strobe is allowed only if the output register is free or emptying this cycle.
    assign up_go      = (up_rem != '0) && (!up_valid || up_ready);
    assign hold_load  = (state == S_UP_CAPTURE);
    assign hold_flush = timeout && (state == S_UP_CHECK);

`ifdef EPT_XFER_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        waiting;

    assign waiting = ((state == S_DN_WAIT) && !dn_valid) ||
                     ((state == S_UP_CHECK) && up_valid && !up_ready);

    always_ff @(posedge uc_clk or negedge uc_reset) begin
        if (!uc_reset) begin
            wd_cnt <= '0;
        end else if (waiting) begin
            wd_cnt <= wd_cnt + 16'd1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign timeout = waiting && (wd_cnt == 16'hFFFF);
`else
    assign timeout = 1'b0;
`endif

    ept_up_holdreg #(
        .DATA_W (DATA_W)
    ) u_up_holdreg (
        .uc_clk    (uc_clk),
        .uc_reset  (uc_reset),
        .load      (hold_load),
        .load_data (out_data),
        .load_last (up_rem == '0),
        .flush     (hold_flush),
        .ready     (up_ready),
        .valid     (up_valid),
        .data      (up_data),
        .last      (up_last)
    );

    always_ff @(posedge uc_clk or negedge uc_reset) begin
        if (!uc_reset) begin
            state     <= S_IDLE;
            phase     <= 1'b0;
            gap_cnt   <= '0;
            dn_len    <= '0;
            dn_cnt    <= '0;
            up_rem    <= '0;
            busy      <= 1'b0;
            fifo_en   <= 1'b0;
            cmd_q     <= CMD_NONE;
            addr_q    <= '0;
            len_q     <= '0;
            data_q    <= '0;
            dn_ready  <= 1'b0;
            dn_done   <= 1'b0;
            up_addr   <= '0;
            up_length <= '0;
            err       <= 1'b0;
        end else begin
            dn_done <= 1'b0;
            err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy    <= 1'b0;
                    fifo_en <= 1'b0;
                    cmd_q   <= CMD_NONE;
                    addr_q  <= '0;
                    len_q   <= '0;
                    data_q  <= '0;
                    if (is_up_cmd(out_cmd)) begin
                        up_addr   <= out_addr;
                        up_length <= out_len;
                        up_rem    <= out_len;
                        state     <= S_UP_CHECK;
                    end else if (dn_start) begin
                        dn_len <= dn_length;
                        busy   <= 1'b1;
                        addr_q <= dn_addr;
                        state  <= S_DN_SEL;
                    end
                end
                S_DN_SEL: begin
                    cmd_q <= CMD_BLOCK_IN;
                    len_q <= dn_len;
                    phase <= 1'b0;
                    state <= S_DN_CMD;
                end
                S_DN_CMD: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        dn_cnt <= '0;
                        cmd_q  <= CMD_NONE;
                        len_q  <= '0;
                        state  <= S_DN_CHECK;
                    end
                end
                S_DN_CHECK: begin
                    if (dn_cnt < dn_len) begin
                        dn_ready <= 1'b1;
                        state    <= S_DN_WAIT;
                    end else begin
                        busy    <= 1'b0;
                        addr_q  <= '0;
                        data_q  <= '0;
                        dn_done <= 1'b1;
                        phase   <= 1'b0;
                        state   <= S_DN_END;
                    end
                end
                S_DN_WAIT: begin
                    if (timeout) begin
                        dn_ready <= 1'b0;
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        addr_q   <= '0;
                        data_q   <= '0;
                        dn_done  <= 1'b1;
                        phase    <= 1'b0;
                        state    <= S_DN_END;
                    end else if (dn_valid) begin
                        dn_ready <= 1'b0;
                        data_q   <= dn_data;
                        fifo_en  <= 1'b1;
                        state    <= S_DN_STROBE;
                    end
                end
                S_DN_STROBE: begin
                    fifo_en <= 1'b0;
                    dn_cnt  <= dn_cnt + 1'b1;
                    gap_cnt <= GAP_LOAD;
                    state   <= S_DN_GAP;
                end
                S_DN_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= S_DN_CHECK;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                S_DN_END: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_UP_CHECK: begin
                    if (timeout) begin
                        err   <= 1'b1;
                        state <= S_UP_DRAIN;
                    end else if (up_rem == '0) begin
                        state <= S_UP_DRAIN;
                    end else if (up_go) begin
                        fifo_en <= 1'b1;
                        state   <= S_UP_STROBE;
                    end
                end
                S_UP_STROBE: begin
                    fifo_en <= 1'b0;
                    up_rem  <= up_rem - 1'b1;
                    state   <= S_UP_CAPTURE;
                end
                S_UP_CAPTURE: begin
                    gap_cnt <= GAP_LOAD;
                    state   <= S_UP_GAP;
                end
                // The last gap cycle folds in the next-strobe decision to sustain 2+GAP_CYCLES per byte.
                S_UP_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (up_rem == '0) begin
                        state <= S_UP_DRAIN;
                    end else if (up_go) begin
                        fifo_en <= 1'b1;
                        state   <= S_UP_STROBE;
                    end else begin
                        state <= S_UP_CHECK;
                    end
                end
                S_UP_DRAIN: begin
                    if ((out_cmd == CMD_NONE) && (!up_valid || up_ready)) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ept_host_block_master.sv
`default_nettype none
// ============================================================================
// tb_ept_host_block_master : directed self-checking bench for ept_host_block_master
// Rev 1.0
// ============================================================================
module tb_ept_host_block_master;

    logic        uc_clk = 1'b0;
    logic        uc_reset = 1'b0;
    logic [23:0] uc_in;
    logic [21:0] uc_out;
    logic        dn_start = 1'b0;
    logic [2:0]  dn_addr = 3'd0;
    logic [7:0]  dn_length = 8'd0;
    logic [7:0]  dn_data;
    logic        dn_valid = 1'b0;
    logic        dn_ready;
    logic        dn_done;
    logic [2:0]  up_addr;
    logic [7:0]  up_length;
    logic [7:0]  up_data;
    logic        up_valid;
    logic        up_ready = 1'b0;
    logic        up_last;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Host byte source and device model state
    logic [7:0] feed [0:15];
    int         feed_idx = 0;
    int         feed_base = 0;
    logic [7:0] dev_bytes [0:15];
    logic [2:0] dev_cmd = 3'd0;
    logic [2:0] dev_addr = 3'd0;
    logic [7:0] dev_len = 8'd0;
    logic [7:0] dev_data = 8'd0;
    int         up_fe = 0;
    int         dev_base = 0;

    // Observation logs
    int         cyc = 0;
    logic [7:0] dn_seen [0:255];
    int         dn_cyc [0:255];
    int         dn_wr = 0;
    logic [8:0] up_seen [0:255];
    int         up_cyc [0:255];
    int         up_wr = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;

    assign dn_data = feed[4'(feed_idx - feed_base)];
    assign uc_out  = {dev_cmd, dev_addr, dev_len, dev_data};

    always #5 uc_clk = ~uc_clk;

    ept_host_block_master dut (
        .uc_clk    (uc_clk),
        .uc_reset  (uc_reset),
        .uc_in     (uc_in),
        .uc_out    (uc_out),
        .dn_start  (dn_start),
        .dn_addr   (dn_addr),
        .dn_length (dn_length),
        .dn_data   (dn_data),
        .dn_valid  (dn_valid),
        .dn_ready  (dn_ready),
        .dn_done   (dn_done),
        .up_addr   (up_addr),
        .up_length (up_length),
        .up_data   (up_data),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .up_last   (up_last),
        .err       (err)
    );

    always @(posedge uc_clk) begin
        cyc <= cyc + 1;
        if (uc_in[22] && uc_in[23]) begin
            dn_seen[dn_wr[7:0]] <= uc_in[7:0];
            dn_cyc[dn_wr[7:0]]  <= cyc;
            dn_wr <= dn_wr + 1;
        end
        if (uc_in[22] && !uc_in[23]) begin
            dev_data <= dev_bytes[4'(up_fe - dev_base)];
            up_fe    <= up_fe + 1;
        end
        if (up_valid && up_ready) begin
            up_seen[up_wr[7:0]] <= {up_last, up_data};
            up_cyc[up_wr[7:0]]  <= cyc;
            up_wr <= up_wr + 1;
        end
        if (dn_valid && dn_ready) feed_idx <= feed_idx + 1;
        if (dn_done) done_cnt <= done_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
    end

    task automatic test_reset();
        uc_reset = 1'b0;
        repeat (3) @(negedge uc_clk);
        checks++;
        if (uc_in !== 24'h0) begin
            errors++; $display("FAIL reset_uc_in: got %h expected %h", uc_in, 24'h0);
        end
        checks++;
        if ({dn_ready, dn_done, up_valid, up_last, err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected %b", {dn_ready, dn_done, up_valid, up_last, err}, 5'b0);
        end
        checks++;
        if ({up_addr, up_length, up_data} !== 19'h0) begin
            errors++; $display("FAIL reset_up_regs: got %h expected %h", {up_addr, up_length, up_data}, 19'h0);
        end
        uc_reset = 1'b1;
        @(negedge uc_clk);
    endtask

    task automatic test_dn_basic();
        int b0, d0, mg;
        feed[0] = 8'hA1; feed[1] = 8'hA2; feed[2] = 8'hA3; feed[3] = 8'hA4;
        feed_base = feed_idx; b0 = dn_wr; d0 = done_cnt;
        dn_addr = 3'd3; dn_length = 8'd4; dn_valid = 1'b1; dn_start = 1'b1;
        @(negedge uc_clk);
        dn_start = 1'b0;
        checks++;
        if (uc_in !== 24'h830000) begin
            errors++; $display("FAIL dn_sel: got %h expected %h", uc_in, 24'h830000);
        end
        @(negedge uc_clk);
        checks++;
        if (uc_in !== 24'hA30400) begin
            errors++; $display("FAIL dn_cmd_1: got %h expected %h", uc_in, 24'hA30400);
        end
        @(negedge uc_clk);
        checks++;
        if (uc_in !== 24'hA30400) begin
            errors++; $display("FAIL dn_cmd_2: got %h expected %h", uc_in, 24'hA30400);
        end
        for (int i = 0; i < 60 && done_cnt == d0; i++) @(negedge uc_clk);
        repeat (4) @(negedge uc_clk);
        dn_valid = 1'b0;
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++; $display("FAIL dn_done_count: got %0d expected 1", done_cnt - d0);
        end
        checks++;
        if (dn_wr - b0 != 4) begin
            errors++; $display("FAIL dn_pulse_count: got %0d expected 4", dn_wr - b0);
        end
        checks++;
        if ({dn_seen[b0], dn_seen[b0+1], dn_seen[b0+2], dn_seen[b0+3]} !== 32'hA1A2A3A4) begin
            errors++; $display("FAIL dn_data: got %h expected %h",
                {dn_seen[b0], dn_seen[b0+1], dn_seen[b0+2], dn_seen[b0+3]}, 32'hA1A2A3A4);
        end
        mg = 1000;
        for (int k = 1; k < 4; k++) if (dn_cyc[b0+k] - dn_cyc[b0+k-1] < mg) mg = dn_cyc[b0+k] - dn_cyc[b0+k-1];
        checks++;
        if (mg < 2) begin
            errors++; $display("FAIL dn_pulse_spacing: got %0d expected at least 2", mg);
        end
        checks++;
        if (feed_idx - feed_base != 4) begin
            errors++; $display("FAIL dn_bytes_consumed: got %0d expected 4", feed_idx - feed_base);
        end
        checks++;
        if (uc_in !== 24'h0) begin
            errors++; $display("FAIL dn_idle_bus: got %h expected %h", uc_in, 24'h0);
        end
    endtask

    task automatic test_dn_zero();
        int b0, d0, at;
        b0 = dn_wr; d0 = done_cnt; at = -1;
        dn_addr = 3'd1; dn_length = 8'd0; dn_start = 1'b1;
        @(negedge uc_clk);
        dn_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (dn_done && at < 0) at = i;
            @(negedge uc_clk);
        end
        checks++;
        if (at != 4) begin
            errors++; $display("FAIL dn_zero_done_latency: got %0d expected 4", at);
        end
        checks++;
        if (dn_wr - b0 != 0) begin
            errors++; $display("FAIL dn_zero_pulses: got %0d expected 0", dn_wr - b0);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++; $display("FAIL dn_zero_done_count: got %0d expected 1", done_cnt - d0);
        end
        checks++;
        if (uc_in !== 24'h0) begin
            errors++; $display("FAIL dn_zero_idle_bus: got %h expected %h", uc_in, 24'h0);
        end
    endtask

    task automatic test_up_basic();
        int u0, lin;
        dev_bytes[0] = 8'h11; dev_bytes[1] = 8'h22; dev_bytes[2] = 8'h33;
        dev_base = up_fe; u0 = up_wr; lin = 0; up_ready = 1'b1;
        dev_addr = 3'd5; dev_len = 8'd3; dev_cmd = 3'd2;
        for (int i = 0; i < 80; i++) begin
            @(negedge uc_clk);
            if (up_fe - dev_base >= 3) lin++;
            if (lin == 1) dev_cmd = 3'd3;
            if (lin == 4) dev_cmd = 3'd0;
        end
        checks++;
        if ({up_addr, up_length} !== {3'd5, 8'd3}) begin
            errors++; $display("FAIL up_hdr: got %h/%h expected 5/03", up_addr, up_length);
        end
        checks++;
        if (up_fe - dev_base != 3) begin
            errors++; $display("FAIL up_pulse_count: got %0d expected 3", up_fe - dev_base);
        end
        checks++;
        if (up_wr - u0 != 3) begin
            errors++; $display("FAIL up_byte_count: got %0d expected 3", up_wr - u0);
        end
        checks++;
        if ({up_seen[u0], up_seen[u0+1], up_seen[u0+2]} !== {9'h011, 9'h022, 9'h133}) begin
            errors++; $display("FAIL up_data_last: got %h %h %h expected 011 022 133",
                up_seen[u0], up_seen[u0+1], up_seen[u0+2]);
        end
        checks++;
        if (up_valid !== 1'b0 || uc_in !== 24'h0) begin
            errors++; $display("FAIL up_idle: got valid=%b bus=%h expected 0/000000", up_valid, uc_in);
        end
    endtask

    task automatic test_up_backpressure();
        int u0, lin, f1;
        dev_bytes[0] = 8'h44; dev_bytes[1] = 8'h55; dev_bytes[2] = 8'h66; dev_bytes[3] = 8'h77;
        dev_base = up_fe; u0 = up_wr; lin = 0; up_ready = 1'b0;
        dev_addr = 3'd2; dev_len = 8'd4; dev_cmd = 3'd2;
        for (int i = 0; i < 40 && !up_valid; i++) @(negedge uc_clk);
        f1 = up_fe - dev_base;
        repeat (10) @(negedge uc_clk);
        checks++;
        if (f1 != 1 || up_fe - dev_base != 1) begin
            errors++; $display("FAIL bp_no_strobe: got %0d then %0d expected 1 then 1", f1, up_fe - dev_base);
        end
        checks++;
        if ({up_valid, up_last, up_data} !== {1'b1, 1'b0, 8'h44}) begin
            errors++; $display("FAIL bp_hold: got v=%b l=%b d=%h expected v=1 l=0 d=44", up_valid, up_last, up_data);
        end
        up_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge uc_clk);
            if (up_fe - dev_base >= 4) lin++;
            if (lin == 1) dev_cmd = 3'd3;
            if (lin == 4) dev_cmd = 3'd0;
        end
        checks++;
        if (up_wr - u0 != 4 || up_fe - dev_base != 4) begin
            errors++; $display("FAIL bp_counts: got bytes=%0d strobes=%0d expected 4/4", up_wr - u0, up_fe - dev_base);
        end
        checks++;
        if ({up_seen[u0], up_seen[u0+1], up_seen[u0+2], up_seen[u0+3]} !== {9'h044, 9'h055, 9'h066, 9'h177}) begin
            errors++; $display("FAIL bp_data: got %h %h %h %h expected 044 055 066 177",
                up_seen[u0], up_seen[u0+1], up_seen[u0+2], up_seen[u0+3]);
        end
    endtask

    task automatic test_simultaneous();
        int u0, b0, d0, lin;
        feed[0] = 8'hB1; feed[1] = 8'hB2;
        feed_base = feed_idx; u0 = up_wr; b0 = dn_wr; d0 = done_cnt; lin = 0;
        dev_bytes[0] = 8'h99; dev_base = up_fe; up_ready = 1'b1;
        dn_addr = 3'd2; dn_length = 8'd2; dn_valid = 1'b1; dn_start = 1'b1;
        dev_addr = 3'd6; dev_len = 8'd1; dev_cmd = 3'd2;
        for (int i = 0; i < 120; i++) begin
            @(negedge uc_clk);
            if (uc_in[23]) dn_start = 1'b0;
            if (up_fe - dev_base >= 1) lin++;
            if (lin == 1) dev_cmd = 3'd3;
            if (lin == 4) dev_cmd = 3'd0;
        end
        dn_start = 1'b0; dn_valid = 1'b0;
        checks++;
        if (up_wr - u0 != 1 || up_seen[u0] !== 9'h199) begin
            errors++; $display("FAIL sim_up: got n=%0d first=%h expected 1/199", up_wr - u0, up_seen[u0]);
        end
        checks++;
        if (dn_wr - b0 != 2 || {dn_seen[b0], dn_seen[b0+1]} !== 16'hB1B2) begin
            errors++; $display("FAIL sim_dn: got n=%0d data=%h%h expected 2/B1B2", dn_wr - b0, dn_seen[b0], dn_seen[b0+1]);
        end
        checks++;
        if (up_cyc[u0] >= dn_cyc[b0]) begin
            errors++; $display("FAIL sim_order: got up@%0d dn@%0d expected up first", up_cyc[u0], dn_cyc[b0]);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++; $display("FAIL sim_done: got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int b0, d0;
        logic seen;
        feed_base = feed_idx; seen = 1'b0;
        dn_addr = 3'd4; dn_length = 8'd3; dn_valid = 1'b0; dn_start = 1'b1;
        @(negedge uc_clk);
        dn_start = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (dn_ready) seen = 1'b1;
            else @(negedge uc_clk);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL rm_reach_wait: got dn_ready=0 expected 1 within 20 cycles");
        end
        #2 uc_reset = 1'b0;
        #1;
        checks++;
        if ({uc_in, dn_ready, dn_done} !== 26'h0) begin
            errors++; $display("FAIL rm_async_clear: got bus=%h rdy=%b expected 000000/0", uc_in, dn_ready);
        end
        @(negedge uc_clk);
        uc_reset = 1'b1;
        @(negedge uc_clk);
        feed[0] = 8'hC5; feed_base = feed_idx; b0 = dn_wr; d0 = done_cnt;
        dn_length = 8'd1; dn_valid = 1'b1; dn_start = 1'b1;
        @(negedge uc_clk);
        dn_start = 1'b0;
        repeat (30) @(negedge uc_clk);
        dn_valid = 1'b0;
        checks++;
        if (dn_wr - b0 != 1 || dn_seen[b0] !== 8'hC5) begin
            errors++; $display("FAIL rm_restart: got n=%0d data=%h expected 1/C5", dn_wr - b0, dn_seen[b0]);
        end
        checks++;
        if (done_cnt - d0 != 1 || uc_in !== 24'h0) begin
            errors++; $display("FAIL rm_done: got done=%0d bus=%h expected 1/000000", done_cnt - d0, uc_in);
        end
    endtask

`ifdef EPT_XFER_TIMEOUT_EN
    task automatic test_timeout();
        int e0, d0, at;
        e0 = err_cnt; d0 = done_cnt; at = -1;
        dn_addr = 3'd1; dn_length = 8'd1; dn_valid = 1'b0; dn_start = 1'b1;
        @(negedge uc_clk);
        dn_start = 1'b0;
        for (int i = 0; i < 66000 && at < 0; i++) begin
            @(negedge uc_clk);
            if (err) at = i;
        end
        repeat (4) @(negedge uc_clk);
        checks++;
        if (at < 65535 || err_cnt - e0 != 1) begin
            errors++; $display("FAIL to_err: got at=%0d pulses=%0d expected >=65535/1", at, err_cnt - e0);
        end
        checks++;
        if (done_cnt - d0 != 1 || uc_in !== 24'h0) begin
            errors++; $display("FAIL to_end: got done=%0d bus=%h expected 1/000000", done_cnt - d0, uc_in);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_dn_basic();
        test_dn_zero();
        test_up_basic();
        test_up_backpressure();
        test_simultaneous();
        test_reset_mid();
`ifdef EPT_XFER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
